datapath: RTL and testbench

- 32-bit single-bus register-transfer datapath, simplified Mini-SRC style, driven step by step by an external control sequencer (testbench or control unit).
- Contains R1–R3, PC, IR, Y, MDR, a 64-bit Z register and an AND-only ALU, all sharing one internal bus.
- Each control strobe gates one register onto the bus or latches the bus into one register on the next clock edge.
- Internal state is exported on observation outputs for verification.

---
 rtl/datapath.sv | 69 ++++++
 tb/tb_datapath.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/datapath.sv
// Single-bus 32-bit register-transfer datapath (Mini-SRC style) with an AND-only ALU.
// An external sequencer steps it one transfer per clock through individual strobes.
module datapath #(
  parameter int WIDTH = 32
) (
  input  logic               clock,
  input  logic               clear,
  input  logic [WIDTH-1:0]   Mdatain,
  input  logic               Read,
  input  logic               MDRin,
  input  logic               MDRout,
  input  logic               PCout,
  input  logic               Zlowout,
  input  logic               R2out,
  input  logic               R3out,
  input  logic               R1in,
  input  logic               R2in,
  input  logic               R3in,
  input  logic               IRin,
  input  logic               Yin,
  input  logic               AND,
  output logic [WIDTH-1:0]   BusMuxOut,
  output logic [WIDTH-1:0]   R1_q,
  output logic [WIDTH-1:0]   R2_q,
  output logic [WIDTH-1:0]   R3_q,
  output logic [WIDTH-1:0]   PC_q,
  output logic [WIDTH-1:0]   IR_q,
  output logic [WIDTH-1:0]   Y_q,
  output logic [WIDTH-1:0]   MDR_q,
  output logic [2*WIDTH-1:0] Z_q
);

  logic [2*WIDTH-1:0] alu_result;

  // Bus source priority: PC, Zlow, MDR, R2, R3; an undriven bus reads as zero.
  always_comb begin
    BusMuxOut = '0;
    if (PCout)        BusMuxOut = PC_q;
    else if (Zlowout) BusMuxOut = Z_q[WIDTH-1:0];
    else if (MDRout)  BusMuxOut = MDR_q;
    else if (R2out)   BusMuxOut = R2_q;
    else if (R3out)   BusMuxOut = R3_q;
  end

  assign alu_result = {{WIDTH{1'b0}}, Y_q & BusMuxOut};

  // Register file stage: every destination samples the pre-edge bus value.
  always_ff @(posedge clock) begin
    if (clear) begin
      R1_q  <= '0;
      R2_q  <= '0;
      R3_q  <= '0;
      PC_q  <= '0;
      IR_q  <= '0;
      Y_q   <= '0;
      MDR_q <= '0;
      Z_q   <= '0;
    end else begin
      if (R1in)  R1_q  <= BusMuxOut;
      if (R2in)  R2_q  <= BusMuxOut;
      if (R3in)  R3_q  <= BusMuxOut;
      if (IRin)  IR_q  <= BusMuxOut;
      if (Yin)   Y_q   <= BusMuxOut;
      if (MDRin) MDR_q <= Read ? Mdatain : BusMuxOut;
      if (AND)   Z_q   <= alu_result;
    end
  end

endmodule

// File: tb/tb_datapath.sv
// Bench for datapath: directed transfer sequences plus randomized strobes,
// all compared against a register-level behavioural model.
module tb_datapath;

  logic        clock = 1'b0;
  logic        clear, Read, MDRin, MDRout, PCout, Zlowout, R2out, R3out;
  logic        R1in, R2in, R3in, IRin, Yin, AND;
  logic [31:0] Mdatain;
  logic [31:0] BusMuxOut, R1_q, R2_q, R3_q, PC_q, IR_q, Y_q, MDR_q;
  logic [63:0] Z_q;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: plain variables updated from the transfer rules.
  logic [31:0] m_r1, m_r2, m_r3, m_pc, m_ir, m_y, m_mdr;
  logic [63:0] m_z;

  datapath #(.WIDTH(32)) dut (
    .clock(clock), .clear(clear), .Mdatain(Mdatain), .Read(Read),
    .MDRin(MDRin), .MDRout(MDRout), .PCout(PCout), .Zlowout(Zlowout),
    .R2out(R2out), .R3out(R3out), .R1in(R1in), .R2in(R2in), .R3in(R3in),
    .IRin(IRin), .Yin(Yin), .AND(AND), .BusMuxOut(BusMuxOut),
    .R1_q(R1_q), .R2_q(R2_q), .R3_q(R3_q), .PC_q(PC_q), .IR_q(IR_q),
    .Y_q(Y_q), .MDR_q(MDR_q), .Z_q(Z_q)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic idle();
    clear = 0; Read = 0; MDRin = 0; MDRout = 0; PCout = 0; Zlowout = 0;
    R2out = 0; R3out = 0; R1in = 0; R2in = 0; R3in = 0; IRin = 0; Yin = 0; AND = 0;
  endtask

  function automatic logic [31:0] model_bus();
    logic [31:0] b;
    b = 32'h0;
    if (PCout)        b = m_pc;
    else if (Zlowout) b = m_z[31:0];
    else if (MDRout)  b = m_mdr;
    else if (R2out)   b = m_r2;
    else if (R3out)   b = m_r3;
    return b;
  endfunction

  // Called just after a rising edge with controls already set: checks the bus,
  // advances through one edge, then checks every register, and drops the strobes.
  task automatic tick();
    logic [31:0] bus;
    bus = model_bus();
    #2;
    check("bus", {32'h0, BusMuxOut}, {32'h0, bus});
    if (clear) begin
      m_r1 = 0; m_r2 = 0; m_r3 = 0; m_pc = 0; m_ir = 0; m_y = 0; m_mdr = 0; m_z = 0;
    end else begin
      if (R1in)  m_r1 = bus;
      if (R2in)  m_r2 = bus;
      if (R3in)  m_r3 = bus;
      if (IRin)  m_ir = bus;
      if (MDRin) m_mdr = Read ? Mdatain : bus;
      if (AND)   m_z = 64'(m_y & bus);
      if (Yin)   m_y = bus;
    end
    @(posedge clock);
    #1;
    check("R1", {32'h0, R1_q}, {32'h0, m_r1});
    check("R2", {32'h0, R2_q}, {32'h0, m_r2});
    check("R3", {32'h0, R3_q}, {32'h0, m_r3});
    check("PC", {32'h0, PC_q}, {32'h0, m_pc});
    check("IR", {32'h0, IR_q}, {32'h0, m_ir});
    check("Y", {32'h0, Y_q}, {32'h0, m_y});
    check("MDR", {32'h0, MDR_q}, {32'h0, m_mdr});
    check("Z", Z_q, m_z);
    idle();
  endtask

  task automatic load_mdr(input logic [31:0] v);
    Read = 1; MDRin = 1; Mdatain = v; tick();
  endtask

  function automatic logic pick(input int pct);
    return ($urandom_range(0, 99) < pct);
  endfunction

  initial begin
    idle();
    Mdatain = 32'h0;
    m_r1 = 0; m_r2 = 0; m_r3 = 0; m_pc = 0; m_ir = 0; m_y = 0; m_mdr = 0; m_z = 0;
    @(posedge clock);
    #1;
    clear = 1; tick();

    // Arbitrary loads, then reset must clear everything.
    load_mdr(32'hDEADBEEF);
    MDRout = 1; R1in = 1; R2in = 1; R3in = 1; IRin = 1; Yin = 1; tick();
    MDRout = 1; AND = 1; tick();
    clear = 1; MDRin = 1; Read = 1; Mdatain = 32'h55; R1in = 1; AND = 1; tick();
    check("rst_r1", {32'h0, R1_q}, 64'h0);
    check("rst_mdr", {32'h0, MDR_q}, 64'h0);
    check("rst_z", Z_q, 64'h0);

    // Register loads through MDR.
    load_mdr(32'h12);
    check("mdr_12", {32'h0, MDR_q}, 64'h12);
    MDRout = 1; R2in = 1; Mdatain = 32'h11; tick();
    check("r2_12", {32'h0, R2_q}, 64'h12);
    check("mdr_hold", {32'h0, MDR_q}, 64'h12);
    load_mdr(32'h14);
    MDRout = 1; R3in = 1; Mdatain = 32'h13; tick();
    check("r3_14", {32'h0, R3_q}, 64'h14);
    load_mdr(32'h18);
    MDRout = 1; R1in = 1; Mdatain = 32'h17; tick();
    check("r1_18", {32'h0, R1_q}, 64'h18);

    // Fetch.
    PCout = 1; #1;
    check("pc_bus", {32'h0, BusMuxOut}, 64'h0);
    tick();
    load_mdr(32'h9);
    MDRout = 1; IRin = 1; tick();
    check("ir_9", {32'h0, IR_q}, 64'h9);

    // AND sequence.
    R2out = 1; Yin = 1; tick();
    check("y_12", {32'h0, Y_q}, 64'h12);
    R3out = 1; AND = 1; tick();
    check("z_and", Z_q, 64'h10);
    Zlowout = 1; R1in = 1; tick();
    check("r1_10", {32'h0, R1_q}, 64'h10);

    // Bus rules: undriven bus, priority, self-load.
    R1in = 1; tick();
    check("r1_zero", {32'h0, R1_q}, 64'h0);
    load_mdr(32'h5);
    MDRout = 1; R2in = 1; tick();
    load_mdr(32'hA);
    MDRout = 1; R2out = 1; #1;
    check("prio_bus", {32'h0, BusMuxOut}, 64'hA);
    tick();
    R2out = 1; R2in = 1; tick();
    check("self_r2", {32'h0, R2_q}, 64'h5);

    // Hold while Mdatain toggles.
    for (int i = 0; i < 5; i++) begin
      Mdatain = ~Mdatain; tick();
    end
    check("hold_mdr", {32'h0, MDR_q}, 64'hA);

    // Randomized strobes against the model.
    for (int i = 0; i < 400; i++) begin
      clear   = pick(2);
      Read    = pick(50);
      MDRin   = pick(30);
      MDRout  = pick(25);
      PCout   = pick(10);
      Zlowout = pick(20);
      R2out   = pick(25);
      R3out   = pick(25);
      R1in    = pick(30);
      R2in    = pick(30);
      R3in    = pick(30);
      IRin    = pick(20);
      Yin     = pick(30);
      AND     = pick(30);
      Mdatain = $urandom;
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
